decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of decoded-instruction entries; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, discards all buffered entries.
REQ-005 SHALL have port in_valid_i, input, 1, fetched instruction present.
REQ-006 SHALL have port in_ready_o, output, 1, buffer can accept an entry.
REQ-007 SHALL have port instr_i, input, 32, fetched instruction word.
REQ-008 SHALL have port pc_i, input, 32, PC of instr_i.
REQ-009 SHALL have port pc_next_i, input, 32, predicted next PC, stored as PC_mux_val.
REQ-010 SHALL have port out_valid_o, output, 1, head entry valid.
REQ-011 SHALL have port out_ready_i, input, 1, downstream accepts the head entry.
REQ-012 SHALL have port ctrl_o, output, rv32i_control_word, decoded head entry.
REQ-013 SHALL have port illegal_o, output, 1, head entry opcode is not a decoded rv32i_opcode.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-015 SHALL decode instr_i combinationally at enqueue and store the full control word plus the illegal bit per entry.
- Fields: instruction, opcode, rs1/rs2/rd, and all five immediates sign-extended per RV32I.
- PC_val = pc_i; PC_mux_val = pc_next_i.
- rs1_data, rs2_data, alu_out and cmp_out = 0; commit = 1.
REQ-016 Decode defaults SHALL be: aluop alu_add, cmpop beq, alumux1 rs1_out, alumux2 i_imm, cmpmux rs2_out, regfilemux alu_out, has_rd 1, masks 0.
REQ-017 Per-opcode decode:
- lui: regfilemux u_imm.
- auipc: alumux pc_out/u_imm.
- jal: branch, pcmux alu_mod2, pc_out/j_imm, regfilemux pc_plus4.
- jalr: as jal but rs1_out/i_imm.
- br: branch, cmpop = funct3, pc_out/b_imm, has_rd 0.
- load: data_mem_read, regfilemux lb/lh/lw/lbu/lhu by funct3.
- store: data_mem_write, s_imm, has_rd 0.
- imm/reg: aluop = funct3; bit30 selects sra (and sub for reg add); slt/sltu select regfilemux br_en with cmpop blt/bltu.
REQ-018 For any opcode not listed in REQ-017, or op_csr, the stored entry SHALL have illegal = 1, has_rd 0, branch 0, data_mem_read 0 and data_mem_write 0.
REQ-019 load_regfile SHALL equal has_rd AND (rd != 0) for every entry.
REQ-020 Storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH, and count_o SHALL equal the number of valid entries.
REQ-021 Handshakes:
- in_ready_o SHALL = (count_o < DEPTH).
- Push = in_valid_i & in_ready_o.
- Pop = out_valid_o & out_ready_i.
- out_valid_o SHALL = (count_o != 0).
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, in_ready_o SHALL be 0 even if a pop occurs in the same cycle.
REQ-024 Latency from push to out_valid_o SHALL be 1 cycle (see REQ-030).
REQ-025 Entries SHALL leave in push order, with ctrl_o/illegal_o stable while out_valid_o=1 and out_ready_i=0.
REQ-026 When out_valid_o=0, ctrl_o and illegal_o SHALL be driven all-zero.
REQ-027 flush_i SHALL have priority: that cycle's push and pop are dropped, and the next cycle has count 0 with pointers at 0.

Reset
REQ-028 While rst=1, the block SHALL hold pointers and count_o at 0, out_valid_o 0, ctrl_o 0 and illegal_o 0, with in_ready_o at 1.
REQ-029 rst asserted mid-operation SHALL discard all entries immediately, asynchronously.

Configuration
REQ-030 Macro DECODE_BUFFER_BYPASS_EN:
- Defined: when the buffer is empty and in_valid_i=1, the decoded word SHALL appear on ctrl_o with out_valid_o=1 in the same cycle.
  - If out_ready_i=1 it is consumed without being stored.
  - Otherwise it is stored and count becomes 1.
- Undefined: no bypass path; latency is 1 cycle.

Verification
REQ-031 Push 0x00500093 (addi x1,x0,5) -> next cycle ctrl_o.i_imm=0x5, load_regfile=1, rd=1, aluop alu_add.
REQ-032 Push 0x00000033 (add x0,x0,x0) -> load_regfile=0; push 0x00000063 (beq) -> branch=1, has_rd=0.
REQ-033 Push 0x123452B7 (lui x5) -> u_imm=0x12345000, regfilemux u_imm; push 0xFFFFFFFF -> illegal_o=1 at head, data_mem_write=0.
REQ-034 DEPTH=4 with out_ready_i=0 and 5 pushes -> in_ready_o=0 after the 4th push, count_o=4; then drain -> entries in order with pointer wrap verified.
REQ-035 Full buffer with flush_i=1 and in_valid_i=1 -> next cycle count_o=0, out_valid_o=0; rst pulse mid-stream -> outputs 0 without a clock edge.
REQ-036 With DECODE_BUFFER_BYPASS_EN defined, empty buffer, push with out_ready_i=1 -> out_valid_o=1 the same cycle and count_o stays 0.

Source files
------------

// File: rtl/decode_buffer.sv
// RV32I decode buffer: instructions are decoded at enqueue and queued as control words.
// Define DECODE_BUFFER_BYPASS_EN to let a push into an empty buffer reach ctrl_o in the same cycle.
package pcmux;
  typedef enum logic [1:0] {pc_plus4 = 2'b00, alu_out = 2'b01, alu_mod2 = 2'b10} pcmux_sel_t;
endpackage

package alumux;
  typedef enum logic {rs1_out = 1'b0, pc_out = 1'b1} alumux1_sel_t;
  typedef enum logic [2:0] {i_imm = 3'd0, u_imm = 3'd1, b_imm = 3'd2, s_imm = 3'd3,
                            j_imm = 3'd4, rs2_out = 3'd5} alumux2_sel_t;
endpackage

package cmpmux;
  typedef enum logic {rs2_out = 1'b0, i_imm = 1'b1} cmpmux_sel_t;
endpackage

package regfilemux;
  typedef enum logic [3:0] {alu_out = 4'd0, br_en = 4'd1, u_imm = 4'd2, lw = 4'd3, pc_plus4 = 4'd4,
                            lb = 4'd5, lbu = 4'd6, lh = 4'd7, lhu = 4'd8} regfilemux_sel_t;
endpackage

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111, op_jalr = 7'b1100111,
    op_br = 7'b1100011, op_load = 7'b0000011, op_store = 7'b0100011, op_imm = 7'b0010011,
    op_reg = 7'b0110011, op_csr = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101,
                            bltu = 3'b110, bgeu = 3'b111} branch_funct3_t;

  typedef enum logic [2:0] {alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
                            alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111} alu_ops;

  typedef struct packed {
    logic [31:0]                 instruction;
    rv32i_opcode                 opcode;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic [4:0]                  rd;
    logic [31:0]                 i_imm;
    logic [31:0]                 s_imm;
    logic [31:0]                 b_imm;
    logic [31:0]                 u_imm;
    logic [31:0]                 j_imm;
    logic [31:0]                 PC_val;
    logic [31:0]                 PC_mux_val;
    logic [31:0]                 rs1_data;
    logic [31:0]                 rs2_data;
    logic [31:0]                 alu_out;
    logic                        cmp_out;
    logic                        commit;
    alu_ops                      aluop;
    branch_funct3_t              cmpop;
    alumux::alumux1_sel_t        alumux1_sel;
    alumux::alumux2_sel_t        alumux2_sel;
    cmpmux::cmpmux_sel_t         cmpmux_sel;
    regfilemux::regfilemux_sel_t regfilemux_sel;
    pcmux::pcmux_sel_t           pcmux_sel;
    logic                        branch;
    logic                        data_mem_read;
    logic                        data_mem_write;
    logic                        has_rd;
    logic                        load_regfile;
    logic [3:0]                  rmask;
    logic [3:0]                  wmask;
  } rv32i_control_word;
endpackage

module decode_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                pc_next_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output rv32i_control_word          ctrl_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  rv32i_control_word dec;
  logic              dec_ill;
  logic [2:0]        funct3;

  assign funct3 = instr_i[14:12];

  always_comb begin
    dec                = '0;
    dec_ill            = 1'b0;
    dec.instruction    = instr_i;
    dec.opcode         = rv32i_opcode'(instr_i[6:0]);
    dec.rs1            = instr_i[19:15];
    dec.rs2            = instr_i[24:20];
    dec.rd             = instr_i[11:7];
    dec.i_imm          = {{21{instr_i[31]}}, instr_i[30:20]};
    dec.s_imm          = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
    dec.b_imm          = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    dec.u_imm          = {instr_i[31:12], 12'h000};
    dec.j_imm          = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    dec.PC_val         = pc_i;
    dec.PC_mux_val     = pc_next_i;
    dec.commit         = 1'b1;
    dec.aluop          = alu_add;
    dec.cmpop          = beq;
    dec.alumux1_sel    = alumux::rs1_out;
    dec.alumux2_sel    = alumux::i_imm;
    dec.cmpmux_sel     = cmpmux::rs2_out;
    dec.regfilemux_sel = regfilemux::alu_out;
    dec.pcmux_sel      = pcmux::pc_plus4;
    dec.has_rd         = 1'b1;
    case (instr_i[6:0])
      op_lui:   dec.regfilemux_sel = regfilemux::u_imm;
      op_auipc: begin
        dec.alumux1_sel = alumux::pc_out;
        dec.alumux2_sel = alumux::u_imm;
      end
      op_jal: begin
        dec.branch         = 1'b1;
        dec.pcmux_sel      = pcmux::alu_mod2;
        dec.alumux1_sel    = alumux::pc_out;
        dec.alumux2_sel    = alumux::j_imm;
        dec.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_jalr: begin
        dec.branch         = 1'b1;
        dec.pcmux_sel      = pcmux::alu_mod2;
        dec.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_br: begin
        dec.branch      = 1'b1;
        dec.cmpop       = branch_funct3_t'(funct3);
        dec.alumux1_sel = alumux::pc_out;
        dec.alumux2_sel = alumux::b_imm;
        dec.has_rd      = 1'b0;
      end
      op_load: begin
        dec.data_mem_read = 1'b1;
        case (funct3)
          3'b000:  dec.regfilemux_sel = regfilemux::lb;
          3'b001:  dec.regfilemux_sel = regfilemux::lh;
          3'b100:  dec.regfilemux_sel = regfilemux::lbu;
          3'b101:  dec.regfilemux_sel = regfilemux::lhu;
          default: dec.regfilemux_sel = regfilemux::lw;
        endcase
      end
      op_store: begin
        dec.data_mem_write = 1'b1;
        dec.alumux2_sel    = alumux::s_imm;
        dec.has_rd         = 1'b0;
      end
      op_imm, op_reg: begin
        // Register ops share the immediate decode, differing only in operand B and sub.
        dec.aluop = alu_ops'(funct3);
        if (instr_i[5]) dec.alumux2_sel = alumux::rs2_out;
        if (funct3 == 3'b101 && instr_i[30]) dec.aluop = alu_sra;
        if (funct3 == 3'b000 && instr_i[30] && instr_i[5]) dec.aluop = alu_sub;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec.regfilemux_sel = regfilemux::br_en;
          dec.cmpop          = (funct3 == 3'b010) ? blt : bltu;
          if (!instr_i[5]) dec.cmpmux_sel = cmpmux::i_imm;
        end
      end
      default: begin
        dec_ill    = 1'b1;
        dec.has_rd = 1'b0;
      end
    endcase
    dec.load_regfile = dec.has_rd & (dec.rd != 5'd0);
  end

  rv32i_control_word mem_q [DEPTH];
  logic [DEPTH-1:0]  ill_q;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty, push, pop, wr_en, rd_en;

  assign empty      = (count_q == '0);
  assign in_ready_o = (count_q < FULL);
  assign push       = in_valid_i & in_ready_o;
  assign pop        = out_valid_o & out_ready_i;
  // A pop while empty can only be a bypassed word, which is consumed without storing.
  assign wr_en      = push & ~flush_i & ~(empty & pop);
  assign rd_en      = pop & ~empty & ~flush_i;
  assign count_o    = count_q;

`ifdef DECODE_BUFFER_BYPASS_EN
  assign out_valid_o = ~empty | (in_valid_i & ~rst);
  assign ctrl_o      = !out_valid_o ? '0 : (empty ? dec : mem_q[head_q]);
  assign illegal_o   = out_valid_o & (empty ? dec_ill : ill_q[head_q]);
`else
  assign out_valid_o = ~empty;
  assign ctrl_o      = out_valid_o ? mem_q[head_q] : '0;
  assign illegal_o   = out_valid_o & ill_q[head_q];
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PW'(1);
      if (rd_en) head_d = head_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only visible while count_q marks it valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= dec;
      ill_q[tail_q] <= dec_ill;
    end
  end
endmodule

// File: tb/tb_decode_buffer.sv
// Directed self-checking bench for decode_buffer (DEPTH=4), with hand-computed expectations.
module tb_decode_buffer;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic              in_ready, out_valid, illegal;
  logic [31:0]       instr = '0, pc = '0, pc_next = '0;
  logic [2:0]        count;
  rv32i_control_word ctrl;
  int                n_chk = 0, n_fail = 0;

  decode_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .pc_next_i(pc_next), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .ctrl_o(ctrl), .illegal_o(illegal), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic push(input logic [31:0] ins);
    instr = ins; pc = 32'h100; pc_next = 32'h104; in_valid = 1'b1;
    tick();
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  task automatic test_reset();
    #1;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_chk++; if (ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got nonzero exp 0"); end
    n_chk++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    instr = 32'h00500093; pc = 32'h100; pc_next = 32'h104; in_valid = 1'b1;
    #1;
`ifdef DECODE_BUFFER_BYPASS_EN
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_same_cycle got %b exp 1", out_valid); end
`else
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_same_cycle got %b exp 0", out_valid); end
`endif
    tick();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL addi_count got %0d exp 1", count); end
    n_chk++; if (ctrl.i_imm !== 32'h5) begin n_fail++; $display("FAIL addi_imm got %h exp 5", ctrl.i_imm); end
    n_chk++; if (ctrl.load_regfile !== 1'b1) begin n_fail++; $display("FAIL addi_ldreg got %b exp 1", ctrl.load_regfile); end
    n_chk++; if (ctrl.rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd got %0d exp 1", ctrl.rd); end
    n_chk++; if (ctrl.aluop !== alu_add) begin n_fail++; $display("FAIL addi_aluop got %0d exp 0", ctrl.aluop); end
    n_chk++; if (ctrl.PC_val !== 32'h100 || ctrl.PC_mux_val !== 32'h104) begin
      n_fail++; $display("FAIL addi_pc got %h/%h exp 100/104", ctrl.PC_val, ctrl.PC_mux_val); end
    n_chk++; if (ctrl.commit !== 1'b1 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL addi_commit_ill got %b/%b exp 1/0", ctrl.commit, illegal); end
    pop();
    n_chk++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL addi_drain got v=%b c=%0d exp 0/0", out_valid, count); end
    n_chk++; if (ctrl !== '0 || illegal !== 1'b0) begin n_fail++; $display("FAIL empty_ctrl_zero got nonzero exp 0"); end
  endtask

  task automatic test_decode();
    push(32'h00000033); push(32'h00000063); push(32'h123452B7); push(32'hFFFFFFFF);
    n_chk++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL dec_full got c=%0d r=%b exp 4/0", count, in_ready); end
    n_chk++; if (ctrl.load_regfile !== 1'b0 || ctrl.has_rd !== 1'b1 || ctrl.opcode !== op_reg) begin
      n_fail++; $display("FAIL add_x0 got ld=%b hr=%b op=%h exp 0/1/33", ctrl.load_regfile, ctrl.has_rd, ctrl.opcode); end
    tick();
    n_chk++; if (ctrl.instruction !== 32'h00000033 || count !== 3'd4) begin
      n_fail++; $display("FAIL head_stable got %h c=%0d exp 00000033/4", ctrl.instruction, count); end
    pop();
    n_chk++; if (ctrl.branch !== 1'b1 || ctrl.has_rd !== 1'b0 || ctrl.cmpop !== beq || ctrl.alumux2_sel !== alumux::b_imm) begin
      n_fail++; $display("FAIL beq got br=%b hr=%b cmp=%0d m2=%0d exp 1/0/0/2", ctrl.branch, ctrl.has_rd, ctrl.cmpop, ctrl.alumux2_sel); end
    pop();
    n_chk++; if (ctrl.u_imm !== 32'h12345000 || ctrl.regfilemux_sel !== regfilemux::u_imm || ctrl.load_regfile !== 1'b1) begin
      n_fail++; $display("FAIL lui got u=%h rf=%0d ld=%b exp 12345000/2/1", ctrl.u_imm, ctrl.regfilemux_sel, ctrl.load_regfile); end
    pop();
    n_chk++; if (illegal !== 1'b1 || ctrl.data_mem_write !== 1'b0 || ctrl.has_rd !== 1'b0 || ctrl.load_regfile !== 1'b0) begin
      n_fail++; $display("FAIL illegal got il=%b w=%b hr=%b ld=%b exp 1/0/0/0", illegal, ctrl.data_mem_write, ctrl.has_rd, ctrl.load_regfile); end
    pop();
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL dec_drain got %0d exp 0", count); end
  endtask

  task automatic test_ops();
    push(32'h402081B3);
    n_chk++; if (ctrl.aluop !== alu_sub || ctrl.rd !== 5'd3) begin
      n_fail++; $display("FAIL sub got op=%0d rd=%0d exp 3/3", ctrl.aluop, ctrl.rd); end
    pop(); push(32'hFFC12203);
    n_chk++; if (ctrl.i_imm !== 32'hFFFFFFFC || ctrl.data_mem_read !== 1'b1 || ctrl.regfilemux_sel !== regfilemux::lw) begin
      n_fail++; $display("FAIL lw got imm=%h rd=%b rf=%0d exp fffffffc/1/3", ctrl.i_imm, ctrl.data_mem_read, ctrl.regfilemux_sel); end
    pop(); push(32'h4032D293);
    n_chk++; if (ctrl.aluop !== alu_sra) begin n_fail++; $display("FAIL srai got %0d exp 2", ctrl.aluop); end
    pop(); push(32'h0010A313);
    n_chk++; if (ctrl.regfilemux_sel !== regfilemux::br_en || ctrl.cmpop !== blt) begin
      n_fail++; $display("FAIL slti got rf=%0d cmp=%0d exp 1/4", ctrl.regfilemux_sel, ctrl.cmpop); end
    pop(); push(32'h0020A423);
    n_chk++; if (ctrl.s_imm !== 32'h8 || ctrl.data_mem_write !== 1'b1 || ctrl.load_regfile !== 1'b0) begin
      n_fail++; $display("FAIL sw got imm=%h w=%b ld=%b exp 8/1/0", ctrl.s_imm, ctrl.data_mem_write, ctrl.load_regfile); end
    pop(); push(32'h010000EF);
    n_chk++; if (ctrl.j_imm !== 32'h10 || ctrl.pcmux_sel !== pcmux::alu_mod2 || ctrl.regfilemux_sel !== regfilemux::pc_plus4 || ctrl.branch !== 1'b1) begin
      n_fail++; $display("FAIL jal got j=%h pc=%0d rf=%0d br=%b exp 10/2/4/1", ctrl.j_imm, ctrl.pcmux_sel, ctrl.regfilemux_sel, ctrl.branch); end
    pop();
  endtask

  task automatic test_back_to_back();
    push(addi_k(1));
    instr = addi_k(2); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_chk++; if (count !== 3'd1 || ctrl.rd !== 5'd2) begin
      n_fail++; $display("FAIL push_pop got c=%0d rd=%0d exp 1/2", count, ctrl.rd); end
    pop();
  endtask

  task automatic test_full_wrap();
    for (int k = 1; k <= 4; k++) push(addi_k(k));
    n_chk++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full got c=%0d r=%b exp 4/0", count, in_ready); end
    push(addi_k(5));
    n_chk++; if (count !== 3'd4 || ctrl.rd !== 5'd1) begin
      n_fail++; $display("FAIL full_drop got c=%0d rd=%0d exp 4/1", count, ctrl.rd); end
    instr = addi_k(5); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got %b exp 0", in_ready); end
    tick();
    for (int k = 2; k <= 4; k++) begin
      n_chk++; if (ctrl.rd !== 5'(k) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_order got rd=%0d v=%b exp %0d/1", ctrl.rd, out_valid, k); end
      pop();
    end
    n_chk++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_empty got c=%0d v=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 4; k++) push(addi_k(k));
    instr = addi_k(6); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    tick();
    n_chk++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ctrl !== '0) begin
      n_fail++; $display("FAIL flush got c=%0d v=%b r=%b exp 0/0/1 ctrl zero", count, out_valid, in_ready); end
    push(addi_k(7));
    n_chk++; if (count !== 3'd1 || ctrl.rd !== 5'd7) begin
      n_fail++; $display("FAIL post_flush got c=%0d rd=%0d exp 1/7", count, ctrl.rd); end
    pop();
  endtask

  task automatic test_async_reset();
    push(addi_k(8)); push(addi_k(9));
    #2 rst = 1'b1;
    #1;
    n_chk++; if (count !== 3'd0 || out_valid !== 1'b0 || ctrl !== '0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_rst got c=%0d v=%b il=%b r=%b exp 0/0/0/1", count, out_valid, illegal, in_ready); end
    #1 rst = 1'b0;
    tick();
    push(addi_k(10));
    n_chk++; if (count !== 3'd1 || ctrl.rd !== 5'd10) begin
      n_fail++; $display("FAIL post_rst got c=%0d rd=%0d exp 1/10", count, ctrl.rd); end
    pop();
  endtask

`ifdef DECODE_BUFFER_BYPASS_EN
  task automatic test_bypass();
    instr = addi_k(3); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b1 || ctrl.rd !== 5'd3 || count !== 3'd0) begin
      n_fail++; $display("FAIL bypass_now got v=%b rd=%0d c=%0d exp 1/3/0", out_valid, ctrl.rd, count); end
    tick();
    n_chk++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_consumed got c=%0d v=%b exp 0/0", count, out_valid); end
    push(addi_k(4));
    n_chk++; if (count !== 3'd1 || ctrl.rd !== 5'd4) begin
      n_fail++; $display("FAIL bypass_stored got c=%0d rd=%0d exp 1/4", count, ctrl.rd); end
    pop();
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_ops();
    test_back_to_back();
    test_full_wrap();
    test_flush();
    test_async_reset();
`ifdef DECODE_BUFFER_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
